fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the EX-stage operand muxes of the 5-stage RV32I pipeline.
- Each operand mux is 3-input: sel 00 = register-file value, 01 = EX/MEM ALU result, 10 = MEM/WB writeback value.
- Tracks destination registers of in-flight instructions and produces registered 2-bit selects for operand A and operand B.
- Detects load-use hazards, requests a one-cycle stall with bubble insertion, and keeps saturating stall/forward event counters.

Parameters:
REG_AW, 5, register address width
CNT_W, 32, width of performance counters

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  decode stage holds a valid instruction
id_rs1  in  REG_AW  decode source register 1
id_rs2  in  REG_AW  decode source register 2
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  REG_AW  decode destination register
id_rd_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
ex_flush  in  1  taken branch/jump resolved in EX; squash decode
stall  out  1  combinational; hold PC and IF/ID registers this cycle
fwd_sel_a  out  2  registered select for operand A mux in EX
fwd_sel_b  out  2  registered select for operand B mux in EX
stall_cnt  out  CNT_W  number of stall cycles, saturating
fwd_cnt  out  CNT_W  number of EX operands forwarded (sel != 00), saturating

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - fwd_sel_a = fwd_sel_b = 00.
  - EX and MEM tracking entries are cleared (we = 0, load = 0, rd = 0).
  - Both counters = 0.
  - Reset mid-operation discards all tracked state immediately.
- Internal state: EX entry {ex_rd, ex_we, ex_load} and MEM entry {mem_rd, mem_we}.
- A match on x0 never counts: rd == 0 is treated as we = 0.
- rsN_hit_ex = id_valid & rsN_used & ex_we & (ex_rd == rsN) & (rsN != 0). rsN_hit_mem is defined the same way against the MEM entry.
- Load-use: stall = ~ex_flush & id_valid & ex_load & (rs1_hit_ex | rs2_hit_ex). This is combinational, in the same cycle.
- ex_flush has priority over stall:
  - stall is forced to 0.
  - The decode instruction is squashed.
- Every rising edge:
  - MEM entry <= EX entry.
  - If ex_flush, stall, or ~id_valid: EX entry <= bubble (we = 0, load = 0), and fwd_sel_a/b <= 00.
  - Otherwise: EX entry <= {id_rd, id_rd_we & (id_rd != 0), id_is_load}.
- Select per operand, evaluated in the same cycle as the EX-entry load (i.e. not a bubble):
  - 01 if rsN_hit_ex (producer moves to MEM).
  - Else 10 if rsN_hit_mem (producer moves to WB).
  - Else 00.
  - The youngest producer wins.
- Stalled load-use instruction:
  - It is re-presented on the next cycle with the load in MEM.
  - It then receives sel 10 (load data from WB).
  - It never receives 01 from a load.
- Register file write-before-read for the WB stage is provided by the register file and is out of scope.
- Counters:
  - stall_cnt += 1 on each edge where stall = 1.
  - fwd_cnt += (new sel_a != 00) + (new sel_b != 00), range 0..2 per edge.
  - Both saturate at all-ones with no wrap; add in CNT_W+1 bits, then clamp.
- Latency:
  - Selects are valid in the cycle the instruction occupies EX, one edge after decode.
  - stall has zero latency.
- The unit is idle when id_valid = 0: no stall, and a bubble enters EX.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - Localparams FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
  - REG_AW default.
  - Pipeline-entry struct type {rd, we, load}.
- One natural sub-module, sat_counter (width param, inc amount 0..2, saturate).
- It is instantiated twice.

Test Plan:
- Reset asserted mid-run, with counters at 5 and sel_a = 01:
  - Immediately sel = 00, counters = 0, stall = 0.
  - Tracking is cleared: a following add reading x5 gets sel 00.
- add x5,x1,x2 then sub x6,x5,x3 back-to-back:
  - sub in EX has fwd_sel_a = 01, fwd_sel_b = 00.
  - fwd_cnt = 1, no stall.
- add x5 ; nop ; or x7,x0,x5:
  - or gets fwd_sel_b = 10.
  - With add x5 ; add x5 ; or x7,x5,x5, both selects = 01 (youngest wins).
- lw x8,0(x1) then add x9,x8,x8:
  - stall = 1 for exactly one cycle and a bubble enters EX.
  - Next cycle add has sel_a = sel_b = 10.
  - stall_cnt = 1, fwd_cnt = 2.
- lw x8 then beq flush asserted in the same cycle as a dependent decode:
  - stall = 0, a bubble enters EX, sel = 00, stall_cnt unchanged.
  - Also: writes/reads to x0 never forward or stall.
- Counter saturation with CNT_W = 4:
  - Drive 20 dependent pairs.
  - fwd_cnt holds at 15 and does not wrap.
  - An increment of 2 at value 14 yields 15.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared types and constants for the RV32I pipeline control
//               blocks (forwarding selects, pipeline tracking entry).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    localparam int REG_AW_DEFAULT = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic [REG_AW_DEFAULT-1:0] rd;
        logic                      we;
        logic                      load;
    } pipe_entry_t;

    localparam pipe_entry_t BUBBLE = '{rd: '0, we: 1'b0, load: 1'b0};

    // The youngest in-flight producer (EX) takes precedence over MEM.
    function automatic logic [1:0] fwd_select(input logic hit_ex, input logic hit_mem);
        logic [1:0] sel;
        sel = FWD_RF;
        if (hit_ex) begin
            sel = FWD_EXMEM;
        end else if (hit_mem) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Event counter adding 0..2 per cycle, clamping at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_sum;

    // One extra bit of headroom exposes the overflow for clamping.
    assign w_sum = {1'b0, r_count} + {{(WIDTH-1){1'b0}}, inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_sum[WIDTH]) begin
            r_count <= '1;
        end else begin
            r_count <= w_sum[WIDTH-1:0];
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
// ============================================================================
// Module      : fwd_hazard_ctrl
// Description : EX-stage operand forwarding and load-use hazard control for
//               the 5-stage RV32I pipeline, with saturating event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              ex_flush,
    output logic              stall,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  fwd_cnt
);

    pipe_entry_t       r_ex;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_we;
    logic [1:0]        r_sel_a;
    logic [1:0]        r_sel_b;

    logic        w_rs1_hit_ex;
    logic        w_rs2_hit_ex;
    logic        w_rs1_hit_mem;
    logic        w_rs2_hit_mem;
    logic        w_stall;
    logic        w_advance;
    logic [1:0]  w_sel_a;
    logic [1:0]  w_sel_b;
    logic [1:0]  w_stall_inc;
    logic [1:0]  w_fwd_inc;
    pipe_entry_t w_id_entry;

    // A zero source register never matches: x0 is hard-wired.
    assign w_rs1_hit_ex  = id_valid & id_rs1_used & r_ex.we & (r_ex.rd == id_rs1) & (id_rs1 != '0);
    assign w_rs2_hit_ex  = id_valid & id_rs2_used & r_ex.we & (r_ex.rd == id_rs2) & (id_rs2 != '0);
    assign w_rs1_hit_mem = id_valid & id_rs1_used & r_mem_we & (r_mem_rd == id_rs1) & (id_rs1 != '0);
    assign w_rs2_hit_mem = id_valid & id_rs2_used & r_mem_we & (r_mem_rd == id_rs2) & (id_rs2 != '0);

    // Load data is not available until WB, so an EX-stage load consumer waits one cycle.
    assign w_stall   = ~ex_flush & id_valid & r_ex.load & (w_rs1_hit_ex | w_rs2_hit_ex);
    assign w_advance = id_valid & ~ex_flush & ~w_stall;

    assign w_sel_a = w_advance ? fwd_select(w_rs1_hit_ex, w_rs1_hit_mem) : FWD_RF;
    assign w_sel_b = w_advance ? fwd_select(w_rs2_hit_ex, w_rs2_hit_mem) : FWD_RF;

    assign w_id_entry = '{rd: id_rd, we: id_rd_we & (id_rd != '0), load: id_is_load};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ex     <= BUBBLE;
            r_mem_rd <= '0;
            r_mem_we <= 1'b0;
            r_sel_a  <= FWD_RF;
            r_sel_b  <= FWD_RF;
        end else begin
            r_mem_rd <= r_ex.rd;
            r_mem_we <= r_ex.we;
            r_ex     <= w_advance ? w_id_entry : BUBBLE;
            r_sel_a  <= w_sel_a;
            r_sel_b  <= w_sel_b;
        end
    end

    assign w_stall_inc = {1'b0, w_stall};
    assign w_fwd_inc   = {1'b0, (w_sel_a != FWD_RF)} + {1'b0, (w_sel_b != FWD_RF)};

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clock),
        .rst   (reset),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_fwd_cnt (
        .clk   (clock),
        .rst   (reset),
        .inc   (w_fwd_inc),
        .count (fwd_cnt)
    );

    assign stall     = w_stall;
    assign fwd_sel_a = r_sel_a;
    assign fwd_sel_b = r_sel_b;

endmodule

`default_nettype wire
